// File: rtl/mu0_regfile.sv
// mu0_regfile -- DEPTH x WIDTH register bank for the MU0 datapath.
// It holds ACC, PC and scratch registers in one block.
//
// Ports:
//   Clk               clock; all state changes on the rising edge
//   Reset             synchronous, active-high; has priority over every other input
//   WrOp[1:0]         write operation: 00 none, 01 load, 10 increment, 11 clear
//   WrAddr[AW-1:0]    write target; an address >= DEPTH drops the write
//   WrData[WIDTH-1:0] load data, used only for WrOp = 01
//   RdEnX, RdAddrX    read port X (A/B); one-cycle registered read
//   RdDataX           registered read data; holds its value while RdEnX = 0,
//                     and reads 0 for an address >= DEPTH
//
// Build option: define MU0_REGFILE_BYPASS_EN to forward the value being
// written to a same-edge read of the same register. By default a read and a
// write to one register on the same edge return the old contents. Register
// contents are the same in both builds.
module mu0_regfile #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       WrOp,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic             RdEnA,
  input  logic [AW-1:0]    RdAddrA,
  output logic [WIDTH-1:0] RdDataA,
  input  logic             RdEnB,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataB
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;

  logic [WIDTH-1:0] regs [DEPTH];

  logic             wr_ok;    // WrAddr names an existing register
  logic             wr_hit;   // a register will change this edge
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_new;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] rd_a_sel;
  logic [WIDTH-1:0] rd_b_sel;

  // The muxes scan the real register indices. Addresses that match no
  // register (>= DEPTH) fall through to the zero defaults, so a non-power-of-2
  // DEPTH needs no separate range check.
  always_comb begin
    wr_ok  = 1'b0;
    wr_old = '0;
    rd_a   = '0;
    rd_b   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (WrAddr  == AW'(i)) begin
        wr_ok  = 1'b1;
        wr_old = regs[i];
      end
      if (RdAddrA == AW'(i)) rd_a = regs[i];
      if (RdAddrB == AW'(i)) rd_b = regs[i];
    end
  end

  always_comb begin
    case (WrOp)
      OP_LOAD: wr_new = WrData;
      OP_INC:  wr_new = wr_old + 1'b1;  // wraps modulo 2^WIDTH
      default: wr_new = '0;             // clear (the value is unused for none)
    endcase
    wr_hit = wr_ok && (WrOp != OP_NONE);
  end

`ifdef MU0_REGFILE_BYPASS_EN
  // Write-through: a read that collides with a live write sees the new value.
  assign rd_a_sel = (wr_hit && RdAddrA == WrAddr) ? wr_new : rd_a;
  assign rd_b_sel = (wr_hit && RdAddrB == WrAddr) ? wr_new : rd_b;
`else
  // Read-before-write: a colliding read returns the pre-edge contents.
  assign rd_a_sel = rd_a;
  assign rd_b_sel = rd_b;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      RdDataA <= '0;
      RdDataB <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_hit && WrAddr == AW'(i)) regs[i] <= wr_new;
      if (RdEnA) RdDataA <= rd_a_sel;
      if (RdEnB) RdDataB <= rd_b_sel;
    end
  end

endmodule

// File: tb/tb_mu0_regfile.sv
// tb_mu0_regfile -- directed, table-driven bench for mu0_regfile.
// A DEPTH=4 instance runs a vector table. A DEPTH=3 instance runs a
// hand-written sequence that covers out-of-range addresses and a reset
// arriving partway through a run of increments.
module tb_mu0_regfile;

`ifdef MU0_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // DEPTH=4 instance
  logic        rst, ena, enb;
  logic [1:0]  op, wa, aa, ab;
  logic [15:0] wd, qa, qb;

  mu0_regfile #(.WIDTH(16), .DEPTH(4)) d4 (
    .Clk(Clk), .Reset(rst), .WrOp(op), .WrAddr(wa), .WrData(wd),
    .RdEnA(ena), .RdAddrA(aa), .RdDataA(qa),
    .RdEnB(enb), .RdAddrB(ab), .RdDataB(qb));

  // DEPTH=3 instance
  logic        s_rst, s_ena, s_enb;
  logic [1:0]  s_op, s_wa, s_aa, s_ab;
  logic [15:0] s_wd, s_qa, s_qb;

  mu0_regfile #(.WIDTH(16), .DEPTH(3)) d3 (
    .Clk(Clk), .Reset(s_rst), .WrOp(s_op), .WrAddr(s_wa), .WrData(s_wd),
    .RdEnA(s_ena), .RdAddrA(s_aa), .RdDataA(s_qa),
    .RdEnB(s_enb), .RdAddrB(s_ab), .RdDataB(s_qb));

  typedef struct {
    logic        rst;
    logic [1:0]  op, wa;
    logic [15:0] wd;
    logic        ena;
    logic [1:0]  aa;
    logic        enb;
    logic [1:0]  ab;
    logic [15:0] ea, eb;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  int   applied = 0;
  int   miscmp  = 0;

  function automatic vec_t mk(logic r, logic [1:0] o, logic [1:0] w, logic [15:0] d,
                              logic ea_en, logic [1:0] a, logic eb_en, logic [1:0] b,
                              logic [15:0] xa, logic [15:0] xb);
    vec_t v;
    v.rst = r; v.op = o; v.wa = w; v.wd = d;
    v.ena = ea_en; v.aa = a; v.enb = eb_en; v.ab = b;
    v.ea = xa; v.eb = xb;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    applied++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One edge on the DEPTH=3 instance, followed by a sample 1 time unit later.
  task automatic s_step(input logic r, input logic [1:0] o, input logic [1:0] w,
                        input logic [15:0] d, input logic ea_en, input logic [1:0] a,
                        input logic eb_en, input logic [1:0] b);
    s_rst = r; s_op = o; s_wa = w; s_wd = d;
    s_ena = ea_en; s_aa = a; s_enb = eb_en; s_ab = b;
    @(posedge Clk); #1;
  endtask

  initial begin
    //             rst op     wa  wd        enA aa  enB ab   expA                     expB
    vecs[0]  = mk(1, 2'b01, 1, 16'hFFFE, 1, 1, 1, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 2'b01, 1, 16'hFFFE, 1, 1, 1, 0, 16'h0000, 16'h0000);
    vecs[2]  = mk(0, 2'b00, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 16'h0000); // r1 not loaded
    vecs[3]  = mk(0, 2'b01, 2, 16'hFFFA, 0, 0, 0, 0, 16'h0000, 16'h0000);
    vecs[4]  = mk(0, 2'b00, 0, 16'h0000, 1, 2, 0, 0, 16'hFFFA, 16'h0000);
    vecs[5]  = mk(0, 2'b00, 0, 16'h0000, 0, 0, 0, 0, 16'hFFFA, 16'h0000); // hold
    vecs[6]  = mk(0, 2'b01, 3, 16'hFFFF, 0, 0, 0, 0, 16'hFFFA, 16'h0000);
    vecs[7]  = mk(0, 2'b10, 3, 16'h1234, 0, 0, 1, 3, 16'hFFFA, BYP ? 16'h0000 : 16'hFFFF);
    vecs[8]  = mk(0, 2'b10, 3, 16'h0000, 0, 0, 1, 3, 16'hFFFA, BYP ? 16'h0001 : 16'h0000);
    vecs[9]  = mk(0, 2'b11, 3, 16'hBEEF, 0, 0, 1, 3, 16'hFFFA, BYP ? 16'h0000 : 16'h0001);
    vecs[10] = mk(0, 2'b00, 0, 16'h0000, 1, 0, 1, 3, 16'h0000, 16'h0000);
    vecs[11] = mk(0, 2'b00, 0, 16'h0000, 1, 1, 1, 2, 16'h0000, 16'hFFFA); // r0..r2 intact
    vecs[12] = mk(0, 2'b01, 1, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'hFFFA);
    vecs[13] = mk(0, 2'b01, 1, 16'hABCD, 1, 1, 0, 0, BYP ? 16'hABCD : 16'h1234, 16'hFFFA);
    vecs[14] = mk(0, 2'b00, 0, 16'h0000, 1, 1, 1, 2, 16'hABCD, 16'hFFFA);
    vecs[15] = mk(0, 2'b00, 0, 16'h0000, 1, 1, 1, 1, 16'hABCD, 16'hABCD);
    vecs[16] = mk(0, 2'b01, 0, 16'h0001, 1, 0, 1, 1, BYP ? 16'h0001 : 16'h0000, 16'hABCD);
    vecs[17] = mk(0, 2'b00, 0, 16'h0000, 1, 0, 1, 3, 16'h0001, 16'h0000);

    // Hold the DEPTH=3 instance in reset while the table runs.
    s_rst = 1; s_op = 0; s_wa = 0; s_wd = 0; s_ena = 0; s_aa = 0; s_enb = 0; s_ab = 0;

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; op = vecs[i].op; wa = vecs[i].wa; wd = vecs[i].wd;
      ena = vecs[i].ena; aa = vecs[i].aa; enb = vecs[i].enb; ab = vecs[i].ab;
      @(posedge Clk); #1;
      check($sformatf("v%0d.A", i), qa, vecs[i].ea);
      check($sformatf("v%0d.B", i), qb, vecs[i].eb);
    end
    rst = 0; op = 0; ena = 0; enb = 0;

    // DEPTH=3: writes and reads to address 3 are dropped.
    s_step(1, 2'b00, 0, 16'h0000, 0, 0, 0, 0);
    check("d3.reset.A", s_qa, 16'h0000);
    s_step(0, 2'b01, 0, 16'h1111, 0, 0, 0, 0);
    s_step(0, 2'b01, 1, 16'h2222, 0, 0, 0, 0);
    s_step(0, 2'b01, 2, 16'h3333, 0, 0, 0, 0);
    // An out-of-range write must not be forwarded to a same-address read.
    s_step(0, 2'b01, 3, 16'h5555, 1, 3, 1, 2);
    check("d3.oob_wr_rd.A", s_qa, 16'h0000);
    check("d3.r2.B",        s_qb, 16'h3333);
    s_step(0, 2'b00, 0, 16'h0000, 1, 0, 1, 1);
    check("d3.r0.A", s_qa, 16'h1111);
    check("d3.r1.B", s_qb, 16'h2222);
    s_step(0, 2'b00, 0, 16'h0000, 1, 3, 1, 2);
    check("d3.oob_rd.A", s_qa, 16'h0000);
    check("d3.r2_kept.B", s_qb, 16'h3333);

    // DEPTH=3: an increment run on r1 is interrupted by reset.
    s_step(0, 2'b10, 1, 16'h0000, 0, 0, 0, 0);
    s_step(0, 2'b10, 1, 16'h0000, 0, 0, 1, 1);
    check("d3.inc.B", s_qb, BYP ? 16'h2224 : 16'h2223);
    s_step(1, 2'b10, 1, 16'h0000, 1, 1, 1, 1);
    check("d3.rst_mid.A", s_qa, 16'h0000);
    check("d3.rst_mid.B", s_qb, 16'h0000);
    s_step(0, 2'b00, 0, 16'h0000, 1, 1, 1, 0);
    check("d3.r1_after_rst.A", s_qa, 16'h0000);
    check("d3.r0_after_rst.B", s_qb, 16'h0000);
    s_step(0, 2'b00, 0, 16'h0000, 1, 2, 0, 0);
    check("d3.r2_after_rst.A", s_qa, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

endmodule
